bus_initiator: RTL

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator_pkg.sv | 23 ++
 rtl/bus_initiator_if.sv | 26 ++
 rtl/bus_initiator.sv | 73 +++++++
 3 files changed

// File: rtl/bus_initiator_pkg.sv
// bus_initiator_pkg: shared bus-cycle types and polarity constants for initiator and responder.
package bus_initiator_pkg;
  typedef enum logic [5:0] {
    TI = 6'b000001,
    T1 = 6'b000010,
    T2 = 6'b000100,
    T3 = 6'b001000,
    TW = 6'b010000,
    T4 = 6'b100000
  } t_state_e;
  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_ADDR,
    RSP_DATA,
    RSP_RECOVER
  } rsp_state_e;
  localparam logic DIR_READ   = 1'b0;
  localparam logic DIR_WRITE  = 1'b1;
  localparam logic IOM_MEM    = 1'b0;
  localparam logic IOM_IO     = 1'b1;
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;
endpackage

// File: rtl/bus_initiator_if.sv
// bus_initiator_if: core request handshake plus the non-tristate bus control/address lines.
interface bus_initiator_if;
  logic        req;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ack;
  logic        done;
  logic [7:0]  rd_data;
  logic        busy;
  logic        READY;
  logic        ALE;
  logic        RD;
  logic        WR;
  logic        IOM;
  logic [11:0] A;
  modport master (
    input  req, req_write, req_io, req_addr, req_wdata, READY,
    output req_ack, done, rd_data, busy, ALE, RD, WR, IOM, A
  );
  modport slave (
    output req, req_write, req_io, req_addr, req_wdata, READY,
    input  req_ack, done, rd_data, busy, ALE, RD, WR, IOM, A
  );
endinterface

// File: rtl/bus_initiator.sv
// bus_initiator: runs one multiplexed-bus T1..T4 cycle (with READY wait states) per accepted core request.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int IDLE_CYCLES = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  bus_initiator_if.master bus,
  inout  wire  [7:0]      AD
);
  t_state_e    state, state_next;
  logic [3:0]  idle_cnt;
  logic        write_r, io_r, ad_oe, accept, strobe;
  logic [11:0] addr_hi;
  logic [7:0]  wdata_r, ad_q, rd_q;
  // the accepting Ti cycle itself counts towards the idle gap
  assign accept = state == TI && bus.req && !RESET && idle_cnt >= 4'(IDLE_CYCLES - 1);
  assign strobe = state inside {T2, T3, TW};
  always_comb begin
    state_next = state;
    unique case (state)
      TI:      state_next = accept ? T1 : TI;
      T1:      state_next = T2;
      T2:      state_next = T3;
      T3, TW:  state_next = bus.READY ? T4 : TW;
      T4:      state_next = TI;
      default: state_next = TI;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= TI;
      idle_cnt <= 4'(IDLE_CYCLES);
      write_r  <= DIR_READ;
      io_r     <= IOM_MEM;
      addr_hi  <= '0;
      wdata_r  <= '0;
      ad_q     <= '0;
      ad_oe    <= 1'b0;
      rd_q     <= '0;
    end else begin
      state    <= state_next;
      idle_cnt <= state == T4 ? 4'd0 :
                  (state == TI && idle_cnt < 4'(IDLE_CYCLES)) ? idle_cnt + 4'd1 : idle_cnt;
      if (accept) begin
        write_r <= bus.req_write;
        io_r    <= bus.req_io;
        addr_hi <= bus.req_addr[19:8];
        wdata_r <= bus.req_wdata;
        ad_q    <= bus.req_addr[7:0];
        ad_oe   <= 1'b1;
      end else if (state == T1) begin
        ad_q  <= wdata_r;
        ad_oe <= write_r == DIR_WRITE;
      end else if (state == T4) begin
        ad_oe <= 1'b0;
      end
      if ((state == T3 || state == TW) && bus.READY && write_r == DIR_READ)
        rd_q <= AD;
    end
  end
  assign bus.ALE     = state == T1;
  assign bus.RD      = strobe && write_r == DIR_READ ? STROBE_ON : STROBE_OFF;
  assign bus.WR      = strobe && write_r == DIR_WRITE ? STROBE_ON : STROBE_OFF;
  assign bus.IOM     = state == TI ? IOM_MEM : io_r;
  assign bus.A       = state == TI ? 12'h000 : addr_hi;
  assign bus.req_ack = accept;
  assign bus.done    = state == T4 && !RESET;
  assign bus.busy    = state != TI && !RESET;
  assign bus.rd_data = rd_q;
  assign AD          = ad_oe ? ad_q : 8'bz;
endmodule
